// File: rtl/add_16.sv
// add_16: registered 32-bit adder made of two ripple-carry halves.
// Define ADD16_PIPE_EN to register the low half first (latency 2).
module add_16_rca #(
    parameter int W = 16
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W:0] c;
    assign c[0] = c_i;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
        assign c[i+1]   = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
    end
    assign c_o = c[W];
endmodule

module add_16 #(
    parameter int HALF_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    output logic [2*HALF_W-1:0] sum,
    output logic                cout
);
    logic [HALF_W-1:0]   s_lo, s_hi;
    logic                c16, c32;
    logic [2*HALF_W-1:0] sum_q;
    logic                cout_q;

    add_16_rca #(.W(HALF_W)) u_lo (
        .x_i(a[HALF_W-1:0]),
        .y_i(b[HALF_W-1:0]),
        .c_i(1'b0),
        .s_o(s_lo),
        .c_o(c16)
    );

`ifdef ADD16_PIPE_EN
    logic [HALF_W-1:0] s_lo_q, a_hi_q, b_hi_q;
    logic              c16_q;

    add_16_rca #(.W(HALF_W)) u_hi (
        .x_i(a_hi_q),
        .y_i(b_hi_q),
        .c_i(c16_q),
        .s_o(s_hi),
        .c_o(c32)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_lo_q <= '0;
            c16_q  <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            s_lo_q <= s_lo;
            c16_q  <= c16;
            a_hi_q <= a[2*HALF_W-1:HALF_W];
            b_hi_q <= b[2*HALF_W-1:HALF_W];
            sum_q  <= {s_hi, s_lo_q};
            cout_q <= c32;
        end
    end
`else
    add_16_rca #(.W(HALF_W)) u_hi (
        .x_i(a[2*HALF_W-1:HALF_W]),
        .y_i(b[2*HALF_W-1:HALF_W]),
        .c_i(c16),
        .s_o(s_hi),
        .c_o(c32)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= {s_hi, s_lo};
            cout_q <= c32;
        end
    end
`endif

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_add_16.sv
// tb_add_16: scoreboard bench for add_16 in either build.
module tb_add_16;
`ifdef ADD16_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [31:0] sum;
    logic        cout;
    logic [32:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0, n_err = 0;

    add_16 dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .sum(sum), .cout(cout));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results still inside the pipeline after reset are zeros.
    task automatic prefill();
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            exp_q.push_back('0);
            tag_q.push_back("reset_fill");
        end
    endtask

    task automatic step(input logic [31:0] x, input logic [31:0] y, input string tag);
        @(negedge clk);
        a = ~x;
        b = y ^ 32'h5a5a_5a5a;
        #1;
        a = x;
        b = y;
        exp_q.push_back({1'b0, x} + {1'b0, y});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), {cout, sum}, exp_q.pop_front());
    endtask

    initial begin
        a = 32'h0000_1234;
        b = 32'h0000_0001;
        #1 rst_n = 1'b0;
        #2 chk("reset_async", {cout, sum}, 33'h0);
        prefill();
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0000_1234, 32'h0000_0001, "after_reset");
        step(32'h0, 32'h0, "0+0");
        step(32'h0, 32'h1, "0+1");
        step(32'h1, 32'h1, "1+1");
        step(32'h3, 32'h3, "3+3");
        step(32'h0000_ffff, 32'h0, "ffff+0");
        step(32'h0000_ffff, 32'h1, "half_carry");
        step(32'hffff_ffff, 32'h1, "wrap_ff");
        step(32'h8000_0000, 32'h8000_0000, "wrap_80");
        step(32'hffff_ffff, 32'hffff_ffff, "max+max");
        step(32'h7fff_ffff, 32'h0000_0001, "top_carry");
        for (int i = 0; i < 20; i++)
            step($urandom, $urandom, "b2b_rand");
        step(32'h1111_1111, 32'h2222_2222, "inflight1");
        step(32'hffff_0000, 32'h0001_ffff, "inflight2");
        #2 rst_n = 1'b0;
        #1 chk("midreset_async", {cout, sum}, 33'h0);
        prefill();
        @(posedge clk);
        #1 chk("midreset_hold", {cout, sum}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0000_00aa, 32'h0000_0055, "post_reset1");
        step(32'hdead_beef, 32'h2152_4111, "post_reset2");
        step(32'hffff_fffe, 32'h0000_0001, "post_reset3");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
